// File: rtl/cdu_counter_pkg.sv
// cdu_counter_pkg: shared pending type, default counter width and saturation-limit helper
package cdu_counter_pkg;
    typedef logic signed [7:0] pend_t;
    localparam int WIDTH_DEF = 15;
    localparam pend_t PEND_ONE = 8'sd1;
    function automatic pend_t sat_lim(input int q);
        return pend_t'(q);
    endfunction
endpackage

// File: rtl/cdu_edge_detect.sv
// cdu_edge_detect: rising-edge pulse from one CDU line.
// CDU_PULSE_SYNC_EN inserts a 2-flop synchroniser ahead of the detector.
module cdu_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic i_in,
    output logic o_rise
);
    logic r_prev;
    logic w_lvl;
`ifdef CDU_PULSE_SYNC_EN
    logic [1:0] r_sync;
    always_ff @(posedge clk) r_sync <= rst ? 2'b00 : {r_sync[0], i_in};
    assign w_lvl = r_sync[1];
`else
    assign w_lvl = i_in;
`endif
    always_ff @(posedge clk) r_prev <= rst ? 1'b0 : w_lvl;
    assign o_rise = w_lvl & ~r_prev;
endmodule

// File: rtl/cdu_pulse_counter.sv
// cdu_pulse_counter: CDU counter cell; buffers +/- pulses and applies one step per service slot.
// CDU_PULSE_SYNC_EN adds 2-flop synchronisers on pcdu_in, mcdu_in and cduz.
module cdu_pulse_counter
    import cdu_counter_pkg::*;
#(
    parameter int WIDTH       = WIDTH_DEF,
    parameter int SERVICE_DIV = 12,
    parameter int QMAX        = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pcdu_in,
    input  logic             mcdu_in,
    input  logic             cduz,
    output logic [WIDTH-1:0] count,
    output pend_t            pending,
    output logic             busy,
    output logic             lost,
    output logic             slot
);
    localparam int TW = $clog2(SERVICE_DIV);
    localparam pend_t LIM = sat_lim(QMAX);
    localparam logic signed [8:0] LIM9 = 9'(LIM);
    localparam logic signed [8:0] ONE9 = 9'(PEND_ONE);
    logic [TW-1:0]     r_tmr;
    logic [WIDTH-1:0]  r_cnt;
    pend_t             r_pend;
    logic              r_lost;
    logic              w_prise, w_mrise, w_z, w_hi, w_lo;
    logic signed [8:0] w_edge, w_adj, w_sum;

    cdu_edge_detect u_plus  (.clk(clk), .rst(rst), .i_in(pcdu_in), .o_rise(w_prise));
    cdu_edge_detect u_minus (.clk(clk), .rst(rst), .i_in(mcdu_in), .o_rise(w_mrise));

`ifdef CDU_PULSE_SYNC_EN
    logic [1:0] r_zsync;
    always_ff @(posedge clk) r_zsync <= rst ? 2'b00 : {r_zsync[0], cduz};
    assign w_z = r_zsync[1];
`else
    assign w_z = cduz;
`endif

    assign slot   = r_tmr == TW'(SERVICE_DIV - 1);
    assign w_edge = (w_prise == w_mrise) ? 9'sd0 : w_prise ? ONE9 : -ONE9;
    assign w_adj  = (!slot || r_pend == '0) ? 9'sd0 : (r_pend > 8'sd0) ? -ONE9 : ONE9;
    // saturation is judged on the combined slot adjustment and new edge
    assign w_sum  = $signed({r_pend[7], r_pend}) + w_adj + w_edge;
    assign w_hi   = w_sum > LIM9;
    assign w_lo   = w_sum < -LIM9;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmr  <= '0;
            r_cnt  <= '0;
            r_pend <= '0;
            r_lost <= 1'b0;
        end else begin
            r_tmr <= slot ? '0 : r_tmr + TW'(1);
            if (w_z) begin
                r_cnt  <= '0;
                r_pend <= '0;
            end else begin
                if (slot && r_pend != '0)
                    r_cnt <= r_cnt + ((r_pend > 8'sd0) ? WIDTH'(1) : {WIDTH{1'b1}});
                r_pend <= w_hi ? LIM : w_lo ? -LIM : pend_t'(w_sum[7:0]);
                if (w_hi || w_lo)
                    r_lost <= 1'b1;
            end
        end
    end

    assign count   = r_cnt;
    assign pending = r_pend;
    assign busy    = r_pend != '0;
    assign lost    = r_lost;
endmodule

// File: doc/cdu_pulse_counter.md
# cdu_pulse_counter

- Accumulates the CDU's increment/decrement pulse outputs (ATpPGH/ATmPGH) into a 15-bit two's-complement angle counter, modelling the computer-side CDU counter cell.
- Sits directly downstream of the CDU top level.
- Edge-detects the pulse lines and buffers net pending pulses in a bounded signed accumulator.
- Applies one increment or decrement per service slot, mirroring the computer's counter-cell cadence.

## Interface
Parameters:
- WIDTH, 15, counter width (modular).
- SERVICE_DIV, 12, clk cycles per service slot (≥2).
- QMAX, 7, magnitude limit of the pending accumulator (1..127).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- pcdu_in  in  1  plus-pulse line (ATpPGH); each 0→1 transition is one +1 pulse.
- mcdu_in  in  1  minus-pulse line (ATmPGH); each 0→1 transition is one −1 pulse.
- cduz  in  1  synchronous zero command (ACDUZ-equivalent), level.
- count  out  WIDTH  counter value.
- pending  out  8  signed net pulses not yet applied.
- busy  out  1  pending ≠ 0.
- lost  out  1  sticky: a pulse was dropped at the QMAX limit.
- slot  out  1  one-cycle strobe marking a service slot.

## Operation
- Edge detect: registered previous value per line; pulse = in & ~prev (post-synchroniser, see Configuration).
- Net edge per cycle: +1, −1, or 0. Both edges in the same cycle cancel to 0 and never set lost.
- Slot timer: 0..SERVICE_DIV−1, free-running. slot=1 when the timer equals SERVICE_DIV−1.
- Update in a slot cycle:
  - pending>0: count←count+1 mod 2^WIDTH, pending decrements.
  - pending<0: count←count−1 mod 2^WIDTH, pending increments.
  - pending=0: no change.
- Net edge in the same cycle is summed into the next pending value together with the slot adjustment.
- Saturation: if pending±edge would exceed ±QMAX, pending holds at the limit and lost←1. Judged after the slot adjustment in that cycle.
- Wrap: 0x3FFF+1→0x4000; 0x7FFF+1→0x0000; 0x0000−1→0x7FFF. No overflow flag.
- cduz=1 (while held):
  - count←0 and pending←0, overriding the slot and any edges in that cycle.
  - lost is preserved.
  - Edge-detect registers keep tracking, so a line held high across cduz release does not produce a pulse.
- lost clears only on rst.

## Timing
- Reset values: count=0, pending=0, busy=0, lost=0, slot=0, slot timer=0, edge/sync registers=0.
- rst overrides cduz.
- Without sync: input rising at edge k is visible in pending after edge k+1.
- With sync: visible after edge k+3.
- Count latency: pending update to count update is ≤SERVICE_DIV cycles. First slot after reset is at cycle SERVICE_DIV−1.
- Throughput: one count step per SERVICE_DIV cycles.
- Pulse spacing: input pulses must be ≥2 cycles apart per line to be counted distinctly. A line held high counts once.
- rst mid-burst: all pending pulses are discarded.

## Configuration
- CDU_PULSE_SYNC_EN defined: each input (pcdu_in, mcdu_in, cduz) passes through a 2-flop synchroniser before use, adding 2 cycles of latency.
- CDU_PULSE_SYNC_EN undefined: inputs are used directly and must be synchronous to clk.

## Structure
- Shared package cdu_counter_pkg holds:
  - the pending type (signed 8-bit);
  - the WIDTH default;
  - a constant for the ones-value saturation limit helper.
- Sub-module cdu_edge_detect is instantiated twice (plus and minus lines): optional synchroniser plus rising-edge pulse, with the ifdef contained inside it.
- cduz uses the synchroniser only.

## Test plan
- Single +pulse after reset, SERVICE_DIV=12, no sync → pending=1 next cycle; count=1 at the first slot; busy drops in the same cycle.
- 5 −pulses spaced 3 cycles from count=0 → count steps to 0x7FFF, 0x7FFE … 0x7FFB, one step per slot; pending returns to 0; lost=0.
- Simultaneous + and − edges on the same cycle → pending unchanged, count unchanged, lost=0.
- 10 +pulses spaced 2 cycles, QMAX=7, SERVICE_DIV=12 → pending saturates at 7, lost=1; final count equals applied slots plus 7 and is less than 10.
- count=0x7FFF with one +pulse → count=0x0000 after the slot; pending=0.
- cduz asserted with pending=4 and count=0x0123, with a +edge in the same cycle → count=0, pending=0; lost retained. With CDU_PULSE_SYNC_EN defined, all latencies shift by +2 cycles.
